// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target exposing an 8-bit register bank to an I2C initiator and to the fabric
module i2c_target_regfile #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         NUM_REGS    = 16,
    parameter int         FILTER_LEN  = 3,
    localparam int        IW          = $clog2(NUM_REGS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          scl,
    inout  wire           sda,
    input  logic [IW-1:0] reg_index,
    input  logic          reg_we,
    input  logic [7:0]    reg_wdata,
    output logic [7:0]    reg_rdata,
    output logic          busy,
    output logic          wr_strobe,
    output logic [IW-1:0] wr_index
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
    } state_t;

    state_t        state;
    logic          scl_s1, scl_s2, sda_s1, sda_s2;
    logic          scl_f, sda_f, scl_q, sda_q;
    logic [CW-1:0] scl_cnt, sda_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [IW-1:0] ptr;
    logic          rw, ack_seen, sda_oe;
    logic [7:0]    regs [NUM_REGS];

    logic          ev_start, ev_stop, ev_rise, ev_fall;
    logic [7:0]    next_byte, rd_byte;
    logic          last_bit, i2c_we;

    // Open-drain pad: only ever pull low or float.
    assign sda = sda_oe ? 1'b0 : 1'bz;

    // Bring the bus pins into the clock domain; idle bus is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            sda_s1 <= sda;
            sda_s2 <= sda_s1;
        end
    end

    // Glitch filter: a level only changes after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scl_f   <= 1'b1;
            sda_f   <= 1'b1;
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            scl_q <= scl_f;
            sda_q <= sda_f;
            if (scl_s2 == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == CW'(FILTER_LEN - 1)) begin
                scl_f   <= scl_s2;
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 1'b1;
            end
            if (sda_s2 == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == CW'(FILTER_LEN - 1)) begin
                sda_f   <= sda_s2;
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 1'b1;
            end
        end
    end

    // Bus events from filtered levels; START/STOP need SCL high on both samples so they never coincide with an SCL edge.
    assign ev_start  = scl_f & scl_q & sda_q & ~sda_f;
    assign ev_stop   = scl_f & scl_q & ~sda_q & sda_f;
    assign ev_rise   = scl_f & ~scl_q;
    assign ev_fall   = ~scl_f & scl_q;
    assign next_byte = {shreg[6:0], sda_f};
    assign last_bit  = (bit_cnt == 3'd7);
    assign rd_byte   = regs[ptr];
    assign i2c_we    = ev_rise && (state == S_WDATA) && last_bit && !ev_start && !ev_stop;

    // Register bank: the I2C write beats a fabric write to the same index in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            reg_rdata <= '0;
        end else begin
            reg_rdata <= regs[reg_index];
            if (i2c_we) begin
                regs[ptr] <= next_byte;
            end
            if (reg_we && !(i2c_we && (reg_index == ptr))) begin
                regs[reg_index] <= reg_wdata;
            end
        end
    end

    // Protocol FSM: shifts bytes on SCL rise, changes SDA only on SCL fall.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            ptr       <= '0;
            rw        <= 1'b0;
            ack_seen  <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_index  <= '0;
        end else begin
            wr_strobe <= 1'b0;
            if (ev_start || ev_stop) begin
                state    <= ev_start ? S_ADDR : S_IDLE;
                bit_cnt  <= '0;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
                ack_seen <= 1'b0;
            end else begin
                case (state)
                    S_ADDR: begin
                        if (ev_rise) begin
                            shreg   <= next_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                if (next_byte[7:1] == TARGET_ADDR) begin
                                    state <= S_ADDR_ACK;
                                    rw    <= next_byte[0];
                                    busy  <= 1'b1;
                                end else begin
                                    state <= S_WAIT_STOP;
                                end
                            end
                        end
                    end
                    S_PTR, S_WDATA: begin
                        if (ev_rise) begin
                            shreg   <= next_byte;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (last_bit && state == S_PTR) begin
                                ptr   <= next_byte[IW-1:0];
                                state <= S_PTR_ACK;
                            end else if (last_bit) begin
                                wr_strobe <= 1'b1;
                                wr_index  <= ptr;
                                ptr       <= ptr + IW'(1);
                                state     <= S_WDATA_ACK;
                            end
                        end
                    end
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        // First fall starts the ACK low, second fall ends it.
                        if (ev_fall) begin
                            if (!sda_oe) begin
                                sda_oe <= 1'b1;
                            end else if (state == S_ADDR_ACK && rw) begin
                                shreg  <= rd_byte;
                                sda_oe <= ~rd_byte[7];
                                state  <= S_RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= (state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                            end
                        end
                    end
                    S_RDATA: begin
                        if (ev_rise) begin
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_cnt <= bit_cnt + 3'd1;
                        end else if (ev_fall) begin
                            if (bit_cnt == 3'd0) begin
                                sda_oe <= 1'b0;
                                state  <= S_RDATA_ACK;
                            end else begin
                                sda_oe <= ~shreg[7];
                            end
                        end
                    end
                    S_RDATA_ACK: begin
                        if (ev_rise) begin
                            if (!sda_f) begin
                                ack_seen <= 1'b1;
                                ptr      <= ptr + IW'(1);
                            end else begin
                                state <= S_WAIT_STOP;
                            end
                        end else if (ev_fall && ack_seen) begin
                            ack_seen <= 1'b0;
                            shreg    <= rd_byte;
                            sda_oe   <= ~rd_byte[7];
                            state    <= S_RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - self-checking bench for i2c_target_regfile
module tb_i2c_target_regfile;

    localparam int Q = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       sda_low = 1'b0;
    wire        sda;
    logic [3:0] reg_index = '0;
    logic       reg_we = 1'b0;
    logic [7:0] reg_wdata = '0;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       wr_strobe;
    logic [3:0] wr_index;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_regs [16];
    logic [3:0] m_ptr = '0;
    logic [3:0] exp_wr [$];
    logic [3:0] idx_q = '0;
    logic       rd_check_en = 1'b0;
    logic       no_drive_en = 1'b0;
    logic       busy_exp_en = 1'b0;
    logic       busy_exp = 1'b0;

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clock = ~clock;

    i2c_target_regfile dut (
        .clock     (clock),
        .reset     (reset),
        .scl       (scl),
        .sda       (sda),
        .reg_index (reg_index),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .wr_strobe (wr_strobe),
        .wr_index  (wr_index)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    always @(posedge clock) idx_q <= reg_index;

    // Single compare process: write strobes against the model's queue, reads, SDA and busy expectations.
    always @(negedge clock) begin
        if (!reset && wr_strobe) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr_strobe actual=%0h required=none", wr_index);
            end else begin
                chk("wr_index", 32'(wr_index), 32'(exp_wr.pop_front()));
            end
        end
        if (rd_check_en) chk("reg_rdata", 32'(reg_rdata), 32'(model_regs[idx_q]));
        if (no_drive_en && !sda_low) chk("sda_not_driven", 32'(sda), 32'd1);
        if (busy_exp_en) chk("busy_level", 32'(busy), 32'(busy_exp));
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bit_io(input logic b, output logic s);
        wait_clks(Q); sda_low = ~b;
        wait_clks(Q); scl = 1'b1;
        wait_clks(Q); #2 s = sda;
        wait_clks(Q); scl = 1'b0;
    endtask

    task automatic i2c_start();
        sda_low = 1'b1;
        wait_clks(Q); scl = 1'b0;
    endtask

    task automatic i2c_rstart();
        wait_clks(Q); sda_low = 1'b0;
        wait_clks(Q); scl = 1'b1;
        wait_clks(Q); sda_low = 1'b1;
        wait_clks(Q); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clks(Q); sda_low = 1'b1;
        wait_clks(Q); scl = 1'b1;
        wait_clks(Q); sda_low = 1'b0;
        wait_clks(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(b[i], s);
        bit_io(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, s);
            d[i] = s;
        end
        bit_io(nack, s);
    endtask

    task automatic tx_write(input logic [6:0] a, input logic [7:0] p,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input int n);
        logic ack, hit;
        logic [7:0] d;
        hit = (a == 7'h42);
        i2c_start();
        write_byte({a, 1'b0}, ack);
        chk("addr_ack", 32'(ack), 32'(hit));
        if (hit) chk("busy_after_addr", 32'(busy), 32'd1);
        write_byte(p, ack);
        chk("ptr_ack", 32'(ack), 32'(hit));
        if (hit) m_ptr = 4'(p % 16);
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? d0 : (k == 1) ? d1 : d2;
            if (hit) begin
                exp_wr.push_back(m_ptr);
                model_regs[m_ptr] = d;
                m_ptr = 4'((m_ptr + 1) % 16);
            end
            write_byte(d, ack);
            chk("data_ack", 32'(ack), 32'(hit));
        end
        i2c_stop();
        chk("busy_after_stop", 32'(busy), 32'd0);
        wait_clks(Q);
    endtask

    task automatic tx_read(input logic [7:0] p, input int n, output logic [7:0] r0, output logic [7:0] r1);
        logic ack;
        logic [7:0] d, e;
        r0 = '0;
        r1 = '0;
        i2c_start();
        write_byte(8'h84, ack);
        chk("rd_addr_w_ack", 32'(ack), 32'd1);
        write_byte(p, ack);
        chk("rd_ptr_ack", 32'(ack), 32'd1);
        m_ptr = 4'(p % 16);
        i2c_rstart();
        write_byte(8'h85, ack);
        chk("rd_addr_r_ack", 32'(ack), 32'd1);
        for (int k = 0; k < n; k++) begin
            e = model_regs[m_ptr];
            read_byte(k == n - 1, d);
            chk("rd_byte", 32'(d), 32'(e));
            if (k == 0) r0 = d;
            if (k == 1) r1 = d;
            if (k != n - 1) m_ptr = 4'((m_ptr + 1) % 16);
        end
        wait_clks(Q);
        chk("sda_released_after_nack", 32'(sda), 32'd1);
        i2c_stop();
        chk("busy_after_read_stop", 32'(busy), 32'd0);
        wait_clks(Q);
    endtask

    task automatic scan();
        @(posedge clock); #2 reg_index = 4'd0;
        @(posedge clock); #2 rd_check_en = 1'b1;
        for (int i = 1; i < 16; i++) begin
            reg_index = 4'(i);
            @(posedge clock); #2;
        end
        @(negedge clock); #1 rd_check_en = 1'b0;
    endtask

    task automatic check_reg(input logic [3:0] idx, input logic [7:0] lit, input string name);
        @(posedge clock); #2 reg_index = idx;
        @(posedge clock); @(posedge clock); #2;
        chk(name, 32'(reg_rdata), 32'(lit));
    endtask

    task automatic fab_write(input logic [3:0] idx, input logic [7:0] d);
        @(posedge clock); #2 reg_index = idx; reg_wdata = d; reg_we = 1'b1;
        @(posedge clock); #2 reg_we = 1'b0;
        model_regs[idx] = d;
    endtask

    task automatic tx_collide();
        logic ack;
        int n;
        i2c_start();
        write_byte(8'h84, ack);
        chk("col_addr_ack", 32'(ack), 32'd1);
        write_byte(8'h05, ack);
        chk("col_ptr_ack", 32'(ack), 32'd1);
        exp_wr.push_back(4'd5);
        model_regs[5] = 8'h22;
        m_ptr = 4'd6;
        @(posedge clock); #2 reg_index = 4'd5; reg_wdata = 8'h11; reg_we = 1'b1;
        n = 0;
        fork
            write_byte(8'h22, ack);
            begin
                while (!wr_strobe && n < 2000) begin
                    @(negedge clock);
                    n++;
                end
                reg_we = 1'b0;
                if (n >= 2000) chk("col_strobe_timeout", 32'(n), 32'd0);
            end
        join
        chk("col_data_ack", 32'(ack), 32'd1);
        i2c_stop();
        wait_clks(Q);
    endtask

    initial begin
        logic [7:0] r0, r1;
        logic [7:0] pb;
        logic s;
        for (int i = 0; i < 16; i++) model_regs[i] = '0;

        // Reset state
        #23;
        chk("rst_reg_rdata", 32'(reg_rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        chk("rst_wr_index", 32'(wr_index), 32'd0);
        chk("rst_sda", 32'(sda), 32'd1);
        wait_clks(2);
        reset = 1'b0;
        wait_clks(10);
        scan();

        // Write 0xA5, 0x5A at pointer 3
        tx_write(7'h42, 8'h03, 8'hA5, 8'h5A, 8'h00, 2);
        chk("write_strobes_consumed", 32'(exp_wr.size()), 32'd0);
        check_reg(4'd3, 8'hA5, "reg3_lit");
        check_reg(4'd4, 8'h5A, "reg4_lit");
        scan();

        // Random read with repeated start
        tx_read(8'h03, 2, r0, r1);
        chk("read0_lit", 32'(r0), 32'hA5);
        chk("read1_lit", 32'(r1), 32'h5A);

        // Wrong address: never driven, never busy, nothing written
        no_drive_en = 1'b1;
        busy_exp_en = 1'b1;
        busy_exp = 1'b0;
        tx_write(7'h48, 8'h01, 8'hFF, 8'h00, 8'h00, 1);
        no_drive_en = 1'b0;
        busy_exp_en = 1'b0;
        scan();

        // Pointer wrap
        tx_write(7'h42, 8'h0F, 8'hC1, 8'hC2, 8'hC3, 3);
        check_reg(4'd15, 8'hC1, "wrap_reg15_lit");
        check_reg(4'd0, 8'hC2, "wrap_reg0_lit");
        check_reg(4'd1, 8'hC3, "wrap_reg1_lit");
        scan();

        // Fabric vs I2C collision on index 5
        tx_collide();
        check_reg(4'd5, 8'h22, "collide_reg5_lit");
        fab_write(4'd9, 8'h3C);
        scan();

        // Reset during the 4th bit of a data byte
        i2c_start();
        write_byte(8'h84, s);
        chk("rst_case_addr_ack", 32'(s), 32'd1);
        write_byte(8'h07, s);
        chk("rst_case_ptr_ack", 32'(s), 32'd1);
        pb = 8'h96;
        for (int i = 7; i >= 5; i--) bit_io(pb[i], s);
        wait_clks(Q); sda_low = ~pb[4];
        wait_clks(Q); scl = 1'b1;
        wait_clks(Q / 2);
        reset = 1'b1;
        #2;
        chk("midrst_sda", 32'(sda), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_wr_strobe", 32'(wr_strobe), 32'd0);
        for (int i = 0; i < 16; i++) model_regs[i] = '0;
        exp_wr.delete();
        m_ptr = '0;
        wait_clks(Q); scl = 1'b0;
        wait_clks(Q); sda_low = 1'b0;
        wait_clks(Q); scl = 1'b1;
        wait_clks(Q);
        reset = 1'b0;
        wait_clks(2 * Q);
        check_reg(4'd7, 8'h00, "midrst_reg7_lit");
        scan();

        // A full transaction works after the abort
        tx_write(7'h42, 8'h07, 8'h96, 8'h00, 8'h00, 1);
        tx_read(8'h07, 2, r0, r1);
        chk("post_rst_read0_lit", 32'(r0), 32'h96);
        chk("post_rst_read1_lit", 32'(r1), 32'h00);

        wait_clks(20);
        chk("all_strobes_seen", 32'(exp_wr.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target_regfile.md
# i2c_target_regfile

I2C target (responder) that exposes a bank of 8-bit registers to an external I2C initiator and to the local fabric. It answers the address, register-pointer and data transactions that our I2C master bridge issues, so FPGA-to-FPGA and loopback links need no external device. It sits next to the Avalon-side logic: the fabric reads and writes the same registers through a simple single-cycle port.

## Interface
- TARGET_ADDR, 7'h42: 7-bit I2C address this block answers to.
- NUM_REGS, 16: number of 8-bit registers; must be a power of two, 2..256.
- FILTER_LEN, 3: consecutive equal samples required before a filtered SCL/SDA level changes.
- Reset: reset, asynchronous, active-high. Clock: clock.
- clock  in  1  system clock; must be ≥ 20× the SCL frequency.
- reset  in  1  asynchronous, active-high.
- scl  in  1  I2C clock from the initiator. No clock stretching.
- sda  inout  1  I2C data, open-drain. The block drives 0 or Z only.
- reg_index  in  log2(NUM_REGS)  fabric register select.
- reg_we  in  1  fabric write strobe.
- reg_wdata  in  8  fabric write data.
- reg_rdata  out  8  registered read of regs[reg_index], updated every cycle.
- busy  out  1  high from accepted address match until STOP or START.
- wr_strobe  out  1  one-cycle pulse when an I2C data byte is written.
- wr_index  out  log2(NUM_REGS)  register written by the last wr_strobe.

## Operation
- Input path: 2-FF synchronizer on scl/sda, then a FILTER_LEN stable-count filter. All decoding uses the filtered levels.
- Event detection, at most one per cycle:
  - START: SDA falls while SCL high.
  - STOP: SDA rises while SCL high.
  - SCL rise and SCL fall edges.
- Bit timing:
  - Input bits are sampled on SCL rise, MSB first.
  - The block changes SDA only on SCL fall.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- IDLE → ADDR on START. START in any state also → ADDR (repeated start). STOP in any state → IDLE.
- ADDR: shift 8 bits.
  - Bits[7:1] == TARGET_ADDR → ADDR_ACK.
  - Otherwise → WAIT_STOP, and SDA is never driven.
- ADDR_ACK: drive SDA low from the SCL fall after bit 8 until the next SCL fall. Then:
  - R/W = 0 → PTR.
  - R/W = 1 → RDATA, with the shift register loaded from regs[ptr] at that SCL fall.
- PTR: shift 8 bits. ptr ← byte mod NUM_REGS. → PTR_ACK (ACK), then → WDATA.
- WDATA: shift 8 bits. The cycle after the 8th SCL rise:
  - regs[ptr] ← byte; wr_strobe = 1; wr_index = ptr.
  - ptr ← ptr+1, wrapping at NUM_REGS-1 → 0.
  - → WDATA_ACK (ACK), then back to WDATA.
- RDATA: drive the shift register's MSB on each SCL fall (0 → drive low, 1 → Z). After 8 bits → RDATA_ACK, with SDA released.
- RDATA_ACK: sample the initiator's bit on SCL rise.
  - 0 (ACK): ptr ← ptr+1 with wrap; load regs[ptr] at the next SCL fall; → RDATA.
  - 1 (NACK) → WAIT_STOP.
- Fabric port:
  - When reg_we is high, regs[reg_index] ← reg_wdata.
  - On the same cycle and same index as an I2C write, the I2C write wins; the fabric write is dropped.
- A read byte is the register value at load time; later writes do not affect a byte in flight.

## Timing
- Reset values:
  - sda released (Z); state IDLE; ptr 0; all regs 0.
  - reg_rdata 0, busy 0, wr_strobe 0, wr_index 0.
- Input latency: 2 (sync) + FILTER_LEN cycles from a pin change to its filtered level.
- reg_rdata = regs[reg_index] one cycle after reg_index or reg_we changes.
- Register update latency: 1 clock after the filtered 8th SCL rise of a WDATA byte; wr_strobe is high for exactly that cycle.
- ACK low window: begins 1 clock after the filtered SCL fall ending bit 8; ends 1 clock after the filtered SCL fall ending bit 9.
- busy:
  - Rises the cycle ADDR_ACK is entered.
  - Falls the cycle a STOP or START is detected.
- Reset mid-transfer releases SDA immediately (asynchronous) and discards any partial byte.
- START/STOP in the middle of a byte aborts that byte: no register write, no ptr change.

## Test plan
- Write: S, 0x84, 0x03, 0xA5, 0x5A, P →
  - regs[3]=0xA5, regs[4]=0x5A.
  - Two wr_strobe pulses (indices 3, 4); ACK on all 4 bytes.
- Random read: S, 0x84, 0x03, Sr, 0x85, read 2 bytes (ACK then NACK), P →
  - Returns 0xA5, 0x5A.
  - SDA released after the NACK; busy low after P.
- Wrong address 0x90 followed by data bytes → SDA never driven low, no register change, busy stays 0.
- Pointer wrap: write 0x0F then 3 data bytes with NUM_REGS=16 → regs[15], regs[0], regs[1] written.
- Collision: fabric reg_we on index 5 with 0x11 in the same cycle as an I2C write of 0x22 to index 5 → regs[5]=0x22.
- Reset asserted during the 4th bit of a data byte → SDA Z, state IDLE, target register unchanged; the next full transaction succeeds.
